sync_fifo_flex: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 4-bit sync_fifo, used as the general buffering element between producer and consumer blocks in one clock domain. It adds configurable width and depth, almost-full and almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. First-word-fall-through read mode can be compiled in.

---
 rtl/sync_fifo_flex_pkg.sv | 38 +++
 rtl/sync_fifo_flex_if.sv | 36 +++
 rtl/sync_fifo_flex_mem.sv | 26 ++
 rtl/sync_fifo_flex.sv | 103 ++++++++++
 tb/tb_sync_fifo_flex.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants, types and helpers for the sync_fifo family.
package sync_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Level value that means "nothing stored"; common to single- and dual-clock variants.
  localparam int unsigned LEVEL_EMPTY = 0;

  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic almost_full;
    logic full;
  } fifo_flags_t;

  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic fifo_flags_t decode_level(input int unsigned lvl,
                                               input int unsigned depth,
                                               input int unsigned af_thresh,
                                               input int unsigned ae_thresh);
    fifo_flags_t f;
    f.empty        = (lvl == LEVEL_EMPTY);
    f.almost_empty = (lvl <= ae_thresh);
    f.almost_full  = (lvl >= af_thresh);
    f.full         = (lvl == depth);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bus of sync_fifo_flex; master drives requests, slave is the FIFO.
interface sync_fifo_flex_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned LVL_W = log2_ceil(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             err_clr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_empty;
  logic             rd_almost_empty;
  logic             wr_full;
  logic             wr_almost_full;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, rd_empty, rd_almost_empty,
           wr_full, wr_almost_full, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, rd_empty, rd_almost_empty,
           wr_full, wr_almost_full, level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// fifo_mem_2p: register-array storage, one synchronous write port, one asynchronous read port.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = log2_ceil(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with thresholds, level and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_flex_if.slave bus
);

  localparam int unsigned ADDR_W = log2_ceil(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam fifo_flags_t RST_FLAGS = decode_level(LEVEL_EMPTY, DEPTH, AF_THRESH, AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_next;
  fifo_flags_t       flags;
  fifo_flags_t       flags_next;
  logic              overflow;
  logic              underflow;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  mem_rdata;

  assign wr_acc = bus.wr_en && !flags.full;
  assign rd_acc = bus.rd_en && !flags.empty;

  always_comb begin
    level_next = level;
    if (wr_acc && !rd_acc)      level_next = level + LVL_W'(1);
    else if (!wr_acc && rd_acc) level_next = level - LVL_W'(1);
    flags_next = decode_level(32'(level_next), DEPTH, AF_THRESH, AE_THRESH);
  end

  // Flags are registered decodes of the next level, so they track the level register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      flags     <= RST_FLAGS;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      level     <= level_next;
      flags     <= flags_next;
      overflow  <= (bus.wr_en && flags.full)  || (overflow  && !bus.err_clr);
      underflow <= (bus.rd_en && flags.empty) || (underflow && !bus.err_clr);
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(bus.wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem_rdata;
  assign bus.rd_valid = !flags.empty;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rdata;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.rd_empty        = flags.empty;
  assign bus.rd_almost_empty = flags.almost_empty;
  assign bus.wr_full         = flags.full;
  assign bus.wr_almost_full  = flags.almost_full;
  assign bus.level           = level;
  assign bus.overflow        = overflow;
  assign bus.underflow       = underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex (WIDTH=8, DEPTH=16, AF=14, AE=2), both read modes.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_flex #(
    .WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic [4:0] lvl;
    logic       rv;
    logic [7:0] rdat;
    logic       emp;
    logic       ae;
    logic       af;
    logic       full;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1ns after the edge.
  task automatic cyc(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    bus.wr_en = wr; bus.wr_data = wd; bus.rd_en = rd; bus.err_clr = clr;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
  endtask

  // Pop one word (optionally with a write) and check it against the expected word.
  task automatic pop_chk(input logic wr, input logic [7:0] wd, input logic [7:0] exp, input string nm);
    bus.wr_en = wr; bus.wr_data = wd; bus.rd_en = 1'b1; bus.err_clr = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    chk({nm, ".data"}, 32'(bus.rd_data), 32'(exp));
    chk({nm, ".valid"}, 32'(bus.rd_valid), 32'd1);
`endif
    @(posedge clk); #1;
`ifndef SYNC_FIFO_FWFT_EN
    chk({nm, ".data"}, 32'(bus.rd_data), 32'(exp));
    chk({nm, ".valid"}, 32'(bus.rd_valid), 32'd1);
`endif
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  initial begin
    //               wr  wd     rd  clr  lvl rv rdat   emp ae af full ovf udf
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 5'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h44, 1'b1, 1'b0, 5'd2, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.level", 32'(bus.level), 32'd0);
    chk("rst.empty", 32'(bus.rd_empty), 32'd1);
    chk("rst.ae", 32'(bus.rd_almost_empty), 32'd1);
    chk("rst.full", 32'(bus.wr_full), 32'd0);
    chk("rst.af", 32'(bus.wr_almost_full), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    chk("rst.udf", 32'(bus.underflow), 32'd0);
    chk("rst.valid", 32'(bus.rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst.data", 32'(bus.rd_data), 32'd0);
`endif

    // Basic table: mixed writes, reads, hold, underflow and clear priority.
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d.empty", i), 32'(bus.rd_empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d.ae", i), 32'(bus.rd_almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d.af", i), 32'(bus.wr_almost_full), 32'(vecs[i].af));
      chk($sformatf("vec%0d.full", i), 32'(bus.wr_full), 32'(vecs[i].full));
      chk($sformatf("vec%0d.ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d.udf", i), 32'(bus.underflow), 32'(vecs[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d.valid", i), 32'(bus.rd_valid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d.data", i), 32'(bus.rd_data), 32'(vecs[i].rdat));
`endif
    end

    // Fill to full, overflow, drain in order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill%0d.level", i), 32'(bus.level), 32'(i + 1));
      chk($sformatf("fill%0d.af", i), 32'(bus.wr_almost_full), 32'((i + 1) >= 14));
      chk($sformatf("fill%0d.full", i), 32'(bus.wr_full), 32'((i + 1) == 16));
    end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf.level", 32'(bus.level), 32'd16);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk(1'b0, 8'h00, 8'(i), $sformatf("drain%0d", i));
    chk("drain.empty", 32'(bus.rd_empty), 32'd1);
    chk("drain.level", 32'(bus.level), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf.clr", 32'(bus.overflow), 32'd0);

    // Full with simultaneous read and write: read wins, write rejected.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    pop_chk(1'b1, 8'hBB, 8'h80, "frw");
    chk("frw.level", 32'(bus.level), 32'd15);
    chk("frw.ovf", 32'(bus.overflow), 32'd1);
    chk("frw.full", 32'(bus.wr_full), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk(1'b0, 8'h00, 8'(8'h80 + i), $sformatf("frwd%0d", i));
    chk("frw.empty", 32'(bus.rd_empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Concurrent read/write across pointer wraps at constant level.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      pop_chk(1'b1, 8'(5 + i), 8'(i), $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.level", i), 32'(bus.level), 32'd5);
    end
    for (int i = 40; i < 45; i++) pop_chk(1'b0, 8'h00, 8'(i), $sformatf("wrapd%0d", i));
    chk("wrap.empty", 32'(bus.rd_empty), 32'd1);
    chk("wrap.ovf", 32'(bus.overflow), 32'd0);

    // Mid-stream reset at level 9 with underflow pending.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst.udf", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("pre_rst.level", 32'(bus.level), 32'd9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.level", 32'(bus.level), 32'd0);
    chk("mrst.empty", 32'(bus.rd_empty), 32'd1);
    chk("mrst.valid", 32'(bus.rd_valid), 32'd0);
    chk("mrst.ovf", 32'(bus.overflow), 32'd0);
    chk("mrst.udf", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mrst.data", 32'(bus.rd_data), 32'd0);
`endif
    rst_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    cyc(1'b1, 8'h9A, 1'b0, 1'b0);
    chk("post_rst.level", 32'(bus.level), 32'd2);
    pop_chk(1'b0, 8'h00, 8'h99, "post_rst0");
    pop_chk(1'b0, 8'h00, 8'h9A, "post_rst1");
    chk("post_rst.empty", 32'(bus.rd_empty), 32'd1);

    // Single word into empty FIFO: fall-through vs registered read.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft.data", 32'(bus.rd_data), 32'h3C);
    chk("fwft.valid", 32'(bus.rd_valid), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.empty", 32'(bus.rd_empty), 32'd1);
    chk("fwft.valid0", 32'(bus.rd_valid), 32'd0);
`else
    chk("std.valid_idle", 32'(bus.rd_valid), 32'd0);
    pop_chk(1'b0, 8'h00, 8'h3C, "std");
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("std.valid_drop", 32'(bus.rd_valid), 32'd0);
    chk("std.data_hold", 32'(bus.rd_data), 32'h3C);
    chk("std.empty", 32'(bus.rd_empty), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
